ex_alu_sequencer: RTL and testbench
===================================

// Module: ex_alu_sequencer
// PURPOSE
// - EX-stage controller sitting between the ID/EX register and the shared 32-bit ALU.
// - Decodes ALUOp/Funct into the 4-bit ALU Operation and drives the ALU operand muxes.
// - Single-cycle ops pass straight through with no added latency.
// - ALUOp 2'b11 (MUL, low XLEN bits) reuses the ALU adder over XLEN cycles as a shift-add
//   sequencer, holding the pipeline via stall.
// PARAMETERS
// - XLEN   32              datapath width
// - CNT_W  $clog2(XLEN)+1  iteration counter width
// PORTS
// - clk        in   1     single clock, rising edge
// - reset      in   1     synchronous, active-high
// - start      in   1     ID/EX holds a valid instruction this cycle
// - ALUOp      in   2     00 add, 01 sub, 10 R-type (Funct), 11 MUL
// - Funct      in   4     {funct7[5], funct3}
// - flush      in   1     kill the in-flight instruction (branch/exception)
// - op_a       in   XLEN  rs1 operand, after forwarding
// - op_b       in   XLEN  rs2/imm operand, after forwarding
// - alu_result in   XLEN  result returned by the shared ALU
// - Operation  out  4     ALU control: 0010 add, 0110 sub, 0000 and, 0001 or
// - alu_a      out  XLEN  ALU operand A
// - alu_b      out  XLEN  ALU operand B
// - result     out  XLEN  EX result to the EX/MEM register
// - done       out  1     result is valid this cycle
// - stall      out  1     freeze PC, IF/ID and ID/EX this cycle
// - illegal    out  1     unsupported Funct under ALUOp 10 (same cycle as done)
// BEHAVIOUR
// - Reset values:
//   - FSM = IDLE; acc, mcand and mplier = 0; cnt = 0.
//   - Outputs then follow IDLE rules with start=0: Operation=0010, alu_a=alu_b=0,
//     result=0, done=0, stall=0, illegal=0.
// - FSM states: IDLE, MUL, DONE.
// - IDLE, start=1, ALUOp!=11 (combinational, zero latency):
//   - Operation from the decode below; alu_a=op_a, alu_b=op_b; result=alu_result; done=1.
// - Decode for ALUOp 10:
//   - Funct 0000 -> 0010 (add); 1000 -> 0110 (sub); 0111 -> 0000 (and); 0110 -> 0001 (or).
//   - Any other Funct -> 0010 and illegal=1.
//   - No latch is inferred: Operation is fully defined for every input combination.
// - IDLE, start=1, ALUOp=11:
//   - stall=1 in the same cycle, done=0.
//   - Next edge: acc<=0, mcand<=op_a, mplier<=op_b, cnt<=0, state<=MUL.
// - MUL, one iteration per cycle, stall=1:
//   - alu_a=acc, alu_b=mcand, Operation=0010.
//   - If mplier[0], acc<=alu_result; otherwise acc holds.
//   - mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
//   - When cnt==XLEN-1 on an edge, state<=DONE. MUL therefore lasts exactly XLEN cycles.
// - DONE, one cycle:
//   - result=acc, done=1, stall=0 so the pipeline captures the result; state<=IDLE.
//   - Latency: start edge to done = XLEN+1 cycles (33 for XLEN=32).
// - Width rule: all arithmetic is modulo 2^XLEN; product bits above XLEN-1 are dropped.
// - start while in MUL or DONE is ignored; the ID/EX register is frozen by stall.
// - flush:
//   - In MUL: state<=IDLE on the next edge, done never asserts, and stall deasserts
//     in that next cycle.
//   - In IDLE: done is forced to 0 for that cycle.
//   - In DONE: done is forced to 0.
// - reset mid-operation: IDLE on the next edge; no done is issued for the aborted MUL.
// - When not in MUL and not in the IDLE+start case, alu_a and alu_b are driven to 0.
// STRUCTURE
// - Package alu_pkg holds:
//   - ALUOp encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_MUL.
//   - Operation codes: OP_ADD, OP_SUB, OP_AND, OP_OR.
//   - Funct codes and the state enum.
// - Sub-module alu_op_decode is the pure combinational ALUOp/Funct -> Operation and illegal
//   decode; it is instantiated once.
// - The top level contains the FSM, the acc/mcand/mplier/cnt registers and the operand muxes.
// TESTING
// - IDLE, start, ALUOp=10, Funct=0000, op_a=5, op_b=7, ALU model adds:
//   same cycle Operation=0010, result=12, done=1, stall=0.
// - ALUOp=10, Funct=1000, op_a=3, op_b=9: Operation=0110, result=0xFFFFFFFA, done=1.
//   Funct=0101: Operation=0010, illegal=1.
// - MUL op_a=6, op_b=7: stall=1 for cycles 0..32; done=1 with result=42 at cycle 33,
//   stall=0 in that cycle.
// - MUL op_a=0xFFFFFFFF, op_b=2: result=0xFFFFFFFE (wrap).
//   Second start pulsed mid-MUL is ignored.
// - MUL, flush asserted at cycle 10: IDLE at cycle 11, stall=0, and no done pulse at
//   any later cycle.
// - MUL, reset at cycle 5: all outputs at reset values next cycle.
//   Then ALUOp=00, op_a=1, op_b=1 gives result=2 with done=1.

Source files
------------

// File: rtl/ex_alu_sequencer_pkg.sv
// Shared encodings for the EX-stage ALU sequencer: ALUOp, ALU Operation and Funct codes,
// plus the sequencer state enum.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_MUL   = 2'b11;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;

    // Funct is {funct7[5], funct3}
    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b1000;
    localparam logic [3:0] FUNCT_AND = 4'b0111;
    localparam logic [3:0] FUNCT_OR  = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ex_alu_sequencer_if.sv
// Bundle of ID/EX-side, ALU-side and EX/MEM-side signals around the sequencer.
// Handshake: start qualifies the ID/EX contents; done qualifies result; while stall is high
// the upstream stages hold start/ALUOp/Funct/op_a/op_b frozen.
interface ex_alu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      ALUOp;
    logic [3:0]      Funct;
    logic            flush;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic [3:0]      Operation;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] result;
    logic            done;
    logic            stall;
    logic            illegal;
    alu_pkg::state_t dbg_state;

    modport master (
        output start, ALUOp, Funct, flush, op_a, op_b, alu_result,
        input  Operation, alu_a, alu_b, result, done, stall, illegal, dbg_state
    );

    modport slave (
        input  start, ALUOp, Funct, flush, op_a, op_b, alu_result,
        output Operation, alu_a, alu_b, result, done, stall, illegal, dbg_state
    );

endinterface

// File: rtl/ex_alu_sequencer_decode.sv
// Pure combinational ALUOp/Funct -> ALU Operation decode with illegal-Funct detection.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [3:0] funct,
    output logic [3:0] operation,
    output logic       illegal
);

    always_comb begin
        operation = OP_ADD;
        illegal   = 1'b0;
        case (alu_op)
            ALUOP_ADD: operation = OP_ADD;
            ALUOP_SUB: operation = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: operation = OP_ADD;
                    FUNCT_SUB: operation = OP_SUB;
                    FUNCT_AND: operation = OP_AND;
                    FUNCT_OR:  operation = OP_OR;
                    default: begin
                        operation = OP_ADD;
                        illegal   = 1'b1;
                    end
                endcase
            end
            // the multiply sequencer only ever needs the adder
            ALUOP_MUL: operation = OP_ADD;
            default:   operation = OP_ADD;
        endcase
    end

endmodule

// File: rtl/ex_alu_sequencer.sv
// EX-stage controller: zero-latency pass-through for single-cycle ops, and a shift-add
// multiply that borrows the shared ALU adder for XLEN cycles while stalling the pipeline.
module ex_alu_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic clk,
    input  logic reset,
    ex_alu_if.slave bus
);

    state_t            state, state_nxt;
    logic [XLEN-1:0]   acc, mcand, mplier;
    logic [CNT_W-1:0]  cnt;

    logic [3:0]        dec_op;
    logic              dec_illegal;

    logic [3:0]        operation_c;
    logic [XLEN-1:0]   alu_a_c, alu_b_c, result_c;
    logic              done_c, stall_c, illegal_c;
    logic              mul_load;

    alu_op_decode u_decode (
        .alu_op    (bus.ALUOp),
        .funct     (bus.Funct),
        .operation (dec_op),
        .illegal   (dec_illegal)
    );

    always_comb begin
        state_nxt   = state;
        operation_c = OP_ADD;
        alu_a_c     = '0;
        alu_b_c     = '0;
        result_c    = '0;
        done_c      = 1'b0;
        stall_c     = 1'b0;
        illegal_c   = 1'b0;
        mul_load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    operation_c = dec_op;
                    alu_a_c     = bus.op_a;
                    alu_b_c     = bus.op_b;
                    if (bus.ALUOp == ALUOP_MUL) begin
                        // a flushed multiply is never launched, so it must not stall either
                        stall_c  = !bus.flush;
                        mul_load = !bus.flush;
                        if (!bus.flush) state_nxt = S_MUL;
                    end else begin
                        result_c  = bus.alu_result;
                        done_c    = !bus.flush;
                        illegal_c = dec_illegal && !bus.flush;
                    end
                end
            end
            S_MUL: begin
                stall_c     = 1'b1;
                operation_c = OP_ADD;
                alu_a_c     = acc;
                alu_b_c     = mcand;
                if (bus.flush)                            state_nxt = S_IDLE;
                else if (cnt == CNT_W'(XLEN - 1))         state_nxt = S_DONE;
            end
            S_DONE: begin
                result_c  = acc;
                done_c    = !bus.flush;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (mul_load) begin
                acc    <= '0;
                mcand  <= bus.op_a;
                mplier <= bus.op_b;
                cnt    <= '0;
            end else if (state == S_MUL) begin
                if (mplier[0]) acc <= bus.alu_result;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    assign bus.Operation = operation_c;
    assign bus.alu_a     = alu_a_c;
    assign bus.alu_b     = alu_b_c;
    assign bus.result    = result_c;
    assign bus.done      = done_c;
    assign bus.stall     = stall_c;
    assign bus.illegal   = illegal_c;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_ex_alu_sequencer.sv
// Directed scoreboard bench for ex_alu_sequencer with a behavioural shared-ALU model.
module tb_ex_alu_sequencer;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic clk;
    logic reset;

    ex_alu_if #(.XLEN(XLEN)) bus ();

    ex_alu_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // shared ALU model
    always_comb begin
        case (bus.Operation)
            OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
            OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
            OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
            OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end

    // scoreboard: {illegal, result}
    logic [XLEN:0] exp_q[$];
    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_done: result %h with no expected entry at %0t", bus.result, $time);
            end else begin
                logic [XLEN:0] e;
                e = exp_q.pop_front();
                check("done_result", bus.result, e[XLEN-1:0]);
                check("done_illegal", XLEN'(bus.illegal), XLEN'(e[XLEN]));
            end
        end
    end

    // driver tasks
    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.ALUOp = ALUOP_ADD;
        bus.Funct = 4'b0000;
        bus.flush = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
    endtask

    task automatic single(input logic [1:0] op, input logic [3:0] f,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp_res, input logic [3:0] exp_op,
                          input logic exp_ill);
        exp_q.push_back({exp_ill, exp_res});
        bus.start = 1'b1;
        bus.ALUOp = op;
        bus.Funct = f;
        bus.op_a  = a;
        bus.op_b  = b;
        @(negedge clk);
        check("single_operation", XLEN'(bus.Operation), XLEN'(exp_op));
        check("single_stall", XLEN'(bus.stall), 0);
        @(posedge clk);
        #1;
        idle_inputs();
        check("single_drained", XLEN'(exp_q.size()), 0);
    endtask

    task automatic mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp_res, input bit mid_start);
        exp_q.push_back({1'b0, exp_res});
        bus.start = 1'b1;
        bus.ALUOp = ALUOP_MUL;
        bus.op_a  = a;
        bus.op_b  = b;
        @(negedge clk);
        check("mul_stall_c0", XLEN'(bus.stall), 1);
        @(posedge clk);
        #1;
        idle_inputs();
        for (int c = 1; c <= XLEN; c++) begin
            if (mid_start && c == 5) begin
                bus.start = 1'b1;
                bus.ALUOp = ALUOP_ADD;
                bus.op_a  = 32'd100;
                bus.op_b  = 32'd200;
            end
            @(negedge clk);
            check("mul_stall_busy", XLEN'(bus.stall), 1);
            @(posedge clk);
            #1;
            idle_inputs();
        end
        @(negedge clk);
        check("mul_stall_done", XLEN'(bus.stall), 0);
        @(posedge clk);
        #1;
        check("mul_drained", XLEN'(exp_q.size()), 0);
    endtask

    task automatic start_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bus.start = 1'b1;
        bus.ALUOp = ALUOP_MUL;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_operation"}, XLEN'(bus.Operation), XLEN'(OP_ADD));
        check({tag, "_alu_a"}, bus.alu_a, 0);
        check({tag, "_alu_b"}, bus.alu_b, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_done"}, XLEN'(bus.done), 0);
        check({tag, "_stall"}, XLEN'(bus.stall), 0);
        check({tag, "_illegal"}, XLEN'(bus.illegal), 0);
        check({tag, "_state"}, XLEN'(bus.dbg_state), XLEN'(S_IDLE));
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single-cycle ops: add, sub, R-type variants, illegal funct
        single(ALUOP_RTYPE, FUNCT_ADD, 32'd5, 32'd7, 32'd12, OP_ADD, 1'b0);
        single(ALUOP_RTYPE, FUNCT_SUB, 32'd3, 32'd9, 32'hFFFF_FFFA, OP_SUB, 1'b0);
        single(ALUOP_RTYPE, 4'b0101, 32'd4, 32'd4, 32'd8, OP_ADD, 1'b1);
        single(ALUOP_RTYPE, FUNCT_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, OP_AND, 1'b0);
        single(ALUOP_RTYPE, FUNCT_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, OP_OR, 1'b0);
        single(ALUOP_ADD, 4'b1111, 32'd20, 32'd22, 32'd42, OP_ADD, 1'b0);
        single(ALUOP_SUB, 4'b0000, 32'd10, 32'd3, 32'd7, OP_SUB, 1'b0);

        // flush on an IDLE single-cycle op suppresses done
        bus.start = 1'b1;
        bus.ALUOp = ALUOP_ADD;
        bus.op_a  = 32'd1;
        bus.op_b  = 32'd2;
        bus.flush = 1'b1;
        @(negedge clk);
        check("idle_flush_done", XLEN'(bus.done), 0);
        @(posedge clk);
        #1;
        idle_inputs();

        // multiply
        mul(32'd6, 32'd7, 32'd42, 1'b0);
        mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
        mul(32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0);

        // flush in MUL at cycle 10
        start_mul(32'd6, 32'd7);
        for (int c = 1; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_stall_c10", XLEN'(bus.stall), 1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_stall_c11", XLEN'(bus.stall), 0);
        check("flush_state_c11", XLEN'(bus.dbg_state), XLEN'(S_IDLE));
        repeat (40) @(negedge clk);
        check("flush_drained", XLEN'(exp_q.size()), 0);

        // reset in MUL at cycle 5
        @(posedge clk);
        #1;
        start_mul(32'd3, 32'd3);
        for (int c = 1; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1;
        single(ALUOP_ADD, 4'b0000, 32'd1, 32'd1, 32'd2, OP_ADD, 1'b0);

        repeat (2) @(posedge clk);
        check("final_drained", XLEN'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
